// File: rtl/camera_controller_pkg.sv
// Shared camera types and constants: fixed-point vectors, home position, FSM encoding.
// ray_marcher benches import this too, so the home pose stays defined in one place.
package camera_controller_pkg;

  typedef logic signed [31:0] fp_t;  // Q16.16

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  localparam fp_t FP_ONE    = 32'sh0001_0000;
  localparam fp_t FP_ZERO   = 32'sh0000_0000;
  localparam fp_t POS_LIMIT = 32'sh0008_0000;
  localparam fp_t DEF_Z     = 32'shFFFD_0000;

  localparam vec3_t HOME_POS    = '{x: FP_ZERO, y: FP_ZERO, z: DEF_Z};
  localparam vec3_t DIR_DEFAULT = '{x: FP_ZERO, y: FP_ZERO, z: FP_ONE};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC_X = 3'd1,
    ST_CALC_Y = 3'd2,
    ST_CALC_Z = 3'd3,
    ST_COMMIT = 3'd4
  } cam_state_t;

  // Field order matches the packed input bus that feeds the synchronizer.
  typedef struct packed {
    logic       btnl;
    logic       btnr;
    logic       btnu;
    logic       btnd;
    logic       fwd;
    logic       back;
    logic [1:0] speed;
    logic       home;
    logic [1:0] frac;
  } cam_inputs_t;

  localparam int CAM_IN_W = $bits(cam_inputs_t);

  function automatic fp_t fp_neg(input fp_t a);
    return -a;
  endfunction

  // Signed per-axis step; opposing inputs cancel.
  function automatic fp_t axis_delta(input logic pos, input logic neg, input fp_t step);
    if (pos && !neg) return step;
    if (neg && !pos) return fp_neg(step);
    return FP_ZERO;
  endfunction

endpackage

// File: rtl/camera_controller_sync2.sv
// Parameterised two-flop synchronizer for asynchronous level inputs.
module camera_controller_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/camera_controller.sv
// Per-frame camera pose updater: snapshots synced controls on new_frame_in, steps one
// axis per cycle through a shared clamped adder, and commits everything at once.
module camera_controller
  import camera_controller_pkg::*;
#(
  parameter fp_t BASE_STEP = 32'sh0000_1000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       new_frame_in,
  input  logic       btnl,
  input  logic       btnr,
  input  logic       btnu,
  input  logic       btnd,
  input  logic       fwd_in,
  input  logic       back_in,
  input  logic [1:0] speed_in,
  input  logic       home_in,
  input  logic [1:0] fractal_sel_in,
  output vec3_t      pos_vec_out,
  output vec3_t      dir_vec_out,
  output logic [1:0] fractal_sel_out,
  output logic       busy_out,
  output logic       overrun_out,
  output logic [15:0] frame_count_out,
  output cam_state_t state_dbg_out
);

  // new_frame_in is a one-cycle strobe with no ready: it is taken only in IDLE,
  // any strobe seen in CALC_X..COMMIT is dropped and recorded in the sticky overrun.

  localparam logic signed [33:0] LIM_HI = 34'(POS_LIMIT);
  localparam logic signed [33:0] LIM_LO = -LIM_HI;

  logic [CAM_IN_W-1:0] raw_in;
  cam_inputs_t         sync_in;

  cam_state_t  state_q, state_d;
  cam_inputs_t snap_q, snap_d;
  vec3_t       nxt_q, nxt_d;
  vec3_t       pos_q, pos_d;
  logic [1:0]  frac_q, frac_d;
  logic        ovr_q, ovr_d;
  logic [15:0] cnt_q, cnt_d;

  fp_t                step;
  fp_t                add_a;
  fp_t                add_b;
  logic signed [33:0] sum;
  fp_t                add_res;

  assign raw_in = {btnl, btnr, btnu, btnd, fwd_in, back_in, speed_in, home_in, fractal_sel_in};

  camera_controller_sync2 #(
    .WIDTH(CAM_IN_W)
  ) u_sync (
    .clk_i (clk_in),
    .rst_ni(rst_in),
    .d_i   (raw_in),
    .q_o   (sync_in)
  );

  assign step = BASE_STEP << snap_q.speed;

  // One adder serves all three axes; the FSM state picks its operands.
  always_comb begin
    add_a = pos_q.x;
    add_b = axis_delta(snap_q.btnr, snap_q.btnl, step);
    case (state_q)
      ST_CALC_Y: begin
        add_a = pos_q.y;
        add_b = axis_delta(snap_q.btnu, snap_q.btnd, step);
      end
      ST_CALC_Z: begin
        add_a = pos_q.z;
        add_b = axis_delta(snap_q.fwd, snap_q.back, step);
      end
      default: ;
    endcase
  end

  assign sum = 34'(add_a) + 34'(add_b);

  always_comb begin
    if (sum > LIM_HI) begin
      add_res = POS_LIMIT;
    end else if (sum < LIM_LO) begin
      add_res = fp_neg(POS_LIMIT);
    end else begin
      add_res = sum[31:0];
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    nxt_d   = nxt_q;
    pos_d   = pos_q;
    frac_d  = frac_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q | (new_frame_in && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (new_frame_in) begin
          snap_d  = sync_in;
          state_d = ST_CALC_X;
        end
      end
      ST_CALC_X: begin
        nxt_d.x = add_res;
        state_d = ST_CALC_Y;
      end
      ST_CALC_Y: begin
        nxt_d.y = add_res;
        state_d = ST_CALC_Z;
      end
      ST_CALC_Z: begin
        nxt_d.z = add_res;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        pos_d   = snap_q.home ? HOME_POS : nxt_q;
        frac_d  = snap_q.frac;
        cnt_d   = cnt_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      nxt_q   <= HOME_POS;
      pos_q   <= HOME_POS;
      frac_q  <= 2'd0;
      ovr_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      nxt_q   <= nxt_d;
      pos_q   <= pos_d;
      frac_q  <= frac_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pos_vec_out     = pos_q;
  assign dir_vec_out     = DIR_DEFAULT;
  assign fractal_sel_out = frac_q;
  assign busy_out        = (state_q != ST_IDLE);
  assign overrun_out     = ovr_q;
  assign frame_count_out = cnt_q;
  assign state_dbg_out   = state_q;

endmodule

// File: tb/tb_camera_controller.sv
// Bench for camera_controller: timeline model of commits checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_camera_controller;
  import camera_controller_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        new_frame_in = 1'b0;
  logic        btnl = 1'b0, btnr = 1'b0, btnu = 1'b0, btnd = 1'b0;
  logic        fwd_in = 1'b0, back_in = 1'b0;
  logic [1:0]  speed_in = 2'd0;
  logic        home_in = 1'b0;
  logic [1:0]  fractal_sel_in = 2'd0;
  vec3_t       pos_vec_out;
  vec3_t       dir_vec_out;
  logic [1:0]  fractal_sel_out;
  logic        busy_out;
  logic        overrun_out;
  logic [15:0] frame_count_out;
  cam_state_t  state_dbg_out;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int n_frames = 0;

  camera_controller dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .new_frame_in   (new_frame_in),
    .btnl           (btnl),
    .btnr           (btnr),
    .btnu           (btnu),
    .btnd           (btnd),
    .fwd_in         (fwd_in),
    .back_in        (back_in),
    .speed_in       (speed_in),
    .home_in        (home_in),
    .fractal_sel_in (fractal_sel_in),
    .pos_vec_out    (pos_vec_out),
    .dir_vec_out    (dir_vec_out),
    .fractal_sel_out(fractal_sel_out),
    .busy_out       (busy_out),
    .overrun_out    (overrun_out),
    .frame_count_out(frame_count_out),
    .state_dbg_out  (state_dbg_out)
  );

  // clock/reset
  initial forever #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    bad = bad + 1;
    $display("test done: total=%0d bad=%0d", total, 0 + bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: inputs as seen two clock edges ago, commit four edges after acceptance.
  typedef struct {
    bit l, r, u, d, f, b, home;
    int speed, frac;
  } smp_t;

  int   m_x, m_y, m_z, m_frac, m_cnt;
  bit   m_ovr;
  int   cyc, last_acc;
  bit   pend;
  int   pend_due, p_x, p_y, p_z, p_frac;
  smp_t h0, h1;

  function automatic int move(input int v, input bit p, input bit n, input int speed);
    longint s;
    longint r;
    s = longint'(4096) << speed;
    r = longint'(v);
    if (p && !n) r = r + s;
    else if (n && !p) r = r - s;
    if (r > 524288) r = 524288;
    if (r < -524288) r = -524288;
    return int'(r);
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_z = -196608; m_frac = 0; m_cnt = 0; m_ovr = 1'b0;
    cyc = 0; last_acc = -100; pend = 1'b0; pend_due = 0;
    h0 = '{default: 0};
    h1 = '{default: 0};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in or negedge rst_in);
      if (!rst_in) begin
        model_reset();
      end else begin
        cyc = cyc + 1;
        if (pend && pend_due == cyc) begin
          m_x = p_x; m_y = p_y; m_z = p_z; m_frac = p_frac;
          m_cnt = (m_cnt + 1) & 16'hFFFF;
          pend = 1'b0;
        end
        if (new_frame_in) begin
          if (cyc - last_acc <= 4) begin
            m_ovr = 1'b1;
          end else begin
            last_acc = cyc;
            pend = 1'b1;
            pend_due = cyc + 4;
            p_frac = h1.frac;
            if (h1.home) begin
              p_x = 0; p_y = 0; p_z = -196608;
            end else begin
              p_x = move(m_x, h1.r, h1.l, h1.speed);
              p_y = move(m_y, h1.u, h1.d, h1.speed);
              p_z = move(m_z, h1.f, h1.b, h1.speed);
            end
          end
        end
        h1 = h0;
        h0.l = btnl; h0.r = btnr; h0.u = btnu; h0.d = btnd;
        h0.f = fwd_in; h0.b = back_in; h0.home = home_in;
        h0.speed = int'(speed_in); h0.frac = int'(fractal_sel_in);
      end
    end
  end

  // scoreboard compare, every cycle
  initial begin
    forever begin
      @(negedge clk_in);
      if (chk_en) begin
        chk("pos_x", pos_vec_out.x, m_x);
        chk("pos_y", pos_vec_out.y, m_y);
        chk("pos_z", pos_vec_out.z, m_z);
        chk("dir_x", dir_vec_out.x, 32'h0000_0000);
        chk("dir_y", dir_vec_out.y, 32'h0000_0000);
        chk("dir_z", dir_vec_out.z, 32'h0001_0000);
        chk("frac", 32'(fractal_sel_out), 32'(m_frac));
        chk("busy", 32'(busy_out), 32'((cyc >= last_acc) && (cyc - last_acc <= 3)));
        chk("overrun", 32'(overrun_out), 32'(m_ovr));
        chk("count", 32'(frame_count_out), 32'(m_cnt & 16'hFFFF));
      end
    end
  end

  // driver tasks
  task automatic set_in(input bit l, input bit r, input bit u, input bit d, input bit f,
                        input bit b, input logic [1:0] spd, input bit hm, input logic [1:0] fr);
    @(posedge clk_in);
    #1;
    btnl = l; btnr = r; btnu = u; btnd = d; fwd_in = f; back_in = b;
    speed_in = spd; home_in = hm; fractal_sel_in = fr;
    repeat (2) @(posedge clk_in);
  endtask

  task automatic pulse();
    @(posedge clk_in);
    #1 new_frame_in = 1'b1;
    @(posedge clk_in);
    #1 new_frame_in = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      pulse();
      repeat (5) @(posedge clk_in);
      n_frames = n_frames + 1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    chk_en = 1'b1;
    @(negedge clk_in);
    chk("rst_x", pos_vec_out.x, 32'h0000_0000);
    chk("rst_z", pos_vec_out.z, 32'hFFFD_0000);
    chk("rst_dir_z", dir_vec_out.z, 32'h0001_0000);
    chk("rst_count", 32'(frame_count_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("model_home_z", m_z, 32'hFFFD_0000);

    // btnr at speed 0: busy N+1..N+4, new x from N+5
    set_in(0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    pulse();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      chk("busy_window", 32'(busy_out), 32'd1);
      if (k == 4) chk("x_before_commit", pos_vec_out.x, 32'h0000_0000);
    end
    @(negedge clk_in);
    chk("busy_done", 32'(busy_out), 32'd0);
    chk("x_one_step", pos_vec_out.x, 32'h0000_1000);
    chk("count_one", 32'(frame_count_out), 32'd1);
    repeat (2) @(posedge clk_in);
    n_frames = n_frames + 1;

    // home, then forward at speed 3 for 6 frames
    set_in(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0);
    frames(1);
    set_in(0, 0, 0, 0, 1, 0, 2'd3, 0, 2'd0);
    frames(6);
    @(negedge clk_in);
    chk("z_six_frames", pos_vec_out.z, 32'h0000_0000);
    chk("model_z_six", m_z, 32'h0000_0000);

    // up clamp, then opposing up+down
    set_in(0, 0, 1, 0, 0, 0, 2'd3, 0, 2'd0);
    frames(200);
    @(negedge clk_in);
    chk("y_clamp_hi", pos_vec_out.y, 32'h0008_0000);
    chk("model_y_clamp", m_y, 32'h0008_0000);
    set_in(0, 0, 1, 1, 0, 0, 2'd3, 0, 2'd1);
    frames(2);
    @(negedge clk_in);
    chk("y_opposed", pos_vec_out.y, 32'h0008_0000);
    chk("frac_one", 32'(fractal_sel_out), 32'd1);

    // left clamp at -8.0 with fwd+back opposed
    set_in(1, 0, 0, 0, 1, 1, 2'd3, 0, 2'd2);
    frames(100);
    @(negedge clk_in);
    chk("x_clamp_lo", pos_vec_out.x, 32'hFFF8_0000);
    chk("z_opposed", pos_vec_out.z, 32'h0000_0000);
    chk("frac_two", 32'(fractal_sel_out), 32'd2);

    // home, move to x=3000, then home with btnl held
    set_in(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1);
    frames(1);
    set_in(0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd1);
    frames(3);
    @(negedge clk_in);
    chk("x_three", pos_vec_out.x, 32'h0000_3000);
    set_in(1, 0, 0, 0, 0, 0, 2'd0, 1, 2'd3);
    frames(1);
    @(negedge clk_in);
    chk("home_x", pos_vec_out.x, 32'h0000_0000);
    chk("home_y", pos_vec_out.y, 32'h0000_0000);
    chk("home_z", pos_vec_out.z, 32'hFFFD_0000);
    chk("home_frac", 32'(fractal_sel_out), 32'd3);

    // btnd at speed 2, two frames
    set_in(0, 0, 0, 1, 0, 0, 2'd2, 0, 2'd3);
    frames(2);
    @(negedge clk_in);
    chk("y_down_spd2", pos_vec_out.y, 32'hFFFF_8000);
    chk("ovr_clear", 32'(overrun_out), 32'd0);
    chk("count_total", 32'(frame_count_out), 32'(n_frames));
    chk("count_literal", 32'(frame_count_out), 32'd317);

    // second pulse at N+2 -> overrun, one commit only
    set_in(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd3);
    pulse();
    @(posedge clk_in);
    #1 new_frame_in = 1'b1;
    @(posedge clk_in);
    #1 new_frame_in = 1'b0;
    repeat (8) @(posedge clk_in);
    @(negedge clk_in);
    chk("overrun_set", 32'(overrun_out), 32'd1);
    chk("overrun_count", 32'(frame_count_out), 32'd318);
    repeat (10) @(posedge clk_in);
    @(negedge clk_in);
    chk("overrun_sticky", 32'(overrun_out), 32'd1);

    // async reset at N+2 of an update
    set_in(0, 1, 0, 0, 0, 0, 2'd3, 0, 2'd2);
    pulse();
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_y", pos_vec_out.y, 32'h0000_0000);
    chk("midrst_z", pos_vec_out.z, 32'hFFFD_0000);
    chk("midrst_count", 32'(frame_count_out), 32'd0);
    chk("midrst_ovr", 32'(overrun_out), 32'd0);
    chk("midrst_busy", 32'(busy_out), 32'd0);
    chk("midrst_frac", 32'(fractal_sel_out), 32'd0);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    repeat (8) @(posedge clk_in);
    @(negedge clk_in);
    chk("after_rst_x", pos_vec_out.x, 32'h0000_0000);
    chk("after_rst_count", 32'(frame_count_out), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/camera_controller.md
Name: camera_controller

Overview:
- Converts the user's button and switch inputs into a per-frame camera state: position vector, direction vector and fractal select.
- Sits directly upstream of ray_marcher and drives its pos_vec_in, dir_vec_in and fractal_sel_in.
- Commits new values only at frame boundaries, signalled by ray_marcher's new_frame_out, so every pixel of a frame is rendered with one stable camera.

Parameters:
- BASE_STEP, 32'h0000_1000 (1/16 in Q16.16): translation per frame at speed 0.
- POS_LIMIT, 32'h0008_0000 (8.0): symmetric clamp on each position component.
- DEF_Z, 32'hFFFD_0000 (-3.0): reset/home z position. Home x and y are 0.

Ports:
- clk_in, input, 1: system clock (sys_clk).
- rst_in, input, 1: reset, asynchronous, active-low.
- new_frame_in, input, 1: single-cycle pulse from ray_marcher new_frame_out.
- btnl, btnr, btnu, btnd, input, 1 each: raw, asynchronous, held levels.
- fwd_in, back_in, input, 1 each: switch levels for +z / -z motion.
- speed_in, input, 2: step = BASE_STEP << speed_in.
- home_in, input, 1: request return to the home position.
- fractal_sel_in, input, 2: requested fractal.
- pos_vec_out, output, vec3: committed camera position.
- dir_vec_out, output, vec3: committed direction, fixed at (0,0,FP_ONE).
- fractal_sel_out, output, 2: committed fractal select.
- busy_out, output, 1: update in progress.
- overrun_out, output, 1: sticky; a new_frame_in arrived while busy.
- frame_count_out, output, 16: number of commits, wraps at 16 bits.

Behaviour:
- Reset (rst_in low, asynchronous):
  - pos_vec_out = (0, 0, DEF_Z); dir_vec_out = (0, 0, FP_ONE).
  - fractal_sel_out = 0, busy_out = 0, overrun_out = 0, frame_count_out = 0.
  - FSM = IDLE; synchronizers and snapshot cleared.
  - Reset mid-update abandons the update; no partial commit is visible.
- All button, switch, home and select inputs pass through 2-flop synchronizers before use.
- FSM states: IDLE, CALC_X, CALC_Y, CALC_Z, COMMIT.
  - IDLE: new_frame_in high at cycle N -> snapshot the synced inputs (buttons, fwd/back, speed, home, fractal_sel); go to CALC_X at N+1.
  - CALC_X: x_next = x + step*(btnr - btnl).
  - CALC_Y: y_next = y + step*(btnu - btnd).
  - CALC_Z: z_next = z + step*(fwd - back).
  - COMMIT: load all outputs from the next registers; increment frame_count_out; return to IDLE.
  - Timing: new outputs are visible from cycle N+5. busy_out is high for cycles N+1 to N+4.
- Opposing inputs both active on one axis (l+r, u+d, fwd+back): no motion on that axis.
- Arithmetic:
  - Use one shared adder.
  - Sum in 34-bit signed, then clamp to [-POS_LIMIT, +POS_LIMIT].
  - A component already at the limit stays there; no wrap.
- home_in set in the snapshot:
  - The commit loads (0, 0, DEF_Z) and ignores the motion inputs.
  - fractal_sel is still updated.
- new_frame_in while busy (states CALC_X to COMMIT): ignored and overrun_out set to 1. overrun_out clears only on reset.
- new_frame_in coinciding with the COMMIT cycle: counts as an overrun. The pulse is not queued.
- dir_vec_out: constant in this revision. The port exists for a later rotation stage.

Decomposition:
- Shared types package: vec3, fp type, FP_ONE, FP_ZERO, fp_neg, and the localparam state enum cam_state_t.
- POS_LIMIT and DEF_Z belong in the package as named constants, so ray_marcher tests use the same home position.
- Sub-module: sync2 (parameterised-width 2-flop synchronizer, async active-low reset), instantiated once over the packed input bus.
- Adder and clamp stay inline.

Test Plan:
- Reset release with no input -> pos=(0,0,FFFD_0000), dir=(0,0,0001_0000), frame_count=0, busy=0.
- btnr held, speed=0, one new_frame_in pulse at N -> busy high N+1..N+4; pos.x = 0000_1000 from N+5; frame_count = 1.
- fwd_in held, speed=3, 6 frames from home -> z = FFFD_0000 + 6*0000_8000 = 0000_0000.
- btnu held, speed=3, 200 frames -> y clamps at 0008_0000 and stays there; btnu+btnd both held -> y unchanged.
- Pulse at N, second pulse at N+2 -> overrun_out = 1 (sticky); exactly one commit; frame_count increments by 1.
- Move to x = 0000_3000, then home_in=1 with btnl held -> pos = (0, 0, FFFD_0000); assert rst_in low at N+2 of an update -> outputs return to reset values immediately.
